// File: rtl/dlab_pkg.sv
// Shared definitions for the datapath lab blocks: operating-mode codes and a
// width helper used to size counters from their maximum value.
package dlab_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Smallest r such that 2**r >= value; clog2(WIDTH+1) bits hold 0..WIDTH.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/d_flip_flop.sv
// Single storage bit: rising-edge flop with asynchronous active-high reset to 0
// and a complementary output.
module d_flip_flop (
   input  logic D,
   input  logic Clock,
   input  logic rst,
   output logic Q,
   output logic Qb
);

   // Capture D on the rising edge; reset clears the bit without a clock.
   always_ff @(posedge Clock or posedge rst) begin
      if (rst) begin
         Q <= 1'b0;
      end else begin
         Q <= D;
      end
   end

   assign Qb = ~Q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift left / shift right / parallel load,
// built from WIDTH reset-to-0 flops. Bits whose reset value is 1 are stored
// inverted so the flop's reset-to-0 produces the required RST_VALUE. A
// saturating counter tracks shifts since the last load or reset.
module universal_shift_register
   import dlab_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RST_VALUE = '0,
   localparam int               CNT_W     = clog2(WIDTH + 1)
) (
   input  logic             Clock,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] D,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qb,
   output logic             sout_l,
   output logic             sout_r,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] ff_d;
   logic [WIDTH-1:0] ff_q;
   logic [WIDTH-1:0] ff_qb;

   // Per-bit 4:1 next-state mux; en=0 or hold keeps the current contents.
   always_comb begin
      q_next = Q;
      if (en) begin
         case (mode)
            MODE_SHL:  q_next = {Q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_next = {sin_r, Q[WIDTH-1:1]};
            MODE_LOAD: q_next = D;
            default:   q_next = Q;
         endcase
      end
   end

   // Invert around flops whose reset value is 1 so reset lands on RST_VALUE.
   assign ff_d = q_next ^ RST_VALUE;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_flip_flop u_ff (
         .D     (ff_d[i]),
         .Clock (Clock),
         .rst   (rst),
         .Q     (ff_q[i]),
         .Qb    (ff_qb[i])
      );
   end

   assign Q      = ff_q ^ RST_VALUE;
   assign Qb     = ff_qb ^ RST_VALUE;
   assign sout_l = Q[WIDTH-1];
   assign sout_r = Q[0];
   assign done   = (shift_cnt == CNT_MAX);

   // Shift counter: cleared by reset or load, counts executed shifts, saturates at WIDTH.
   always_ff @(posedge Clock or posedge rst) begin
      if (rst) begin
         shift_cnt <= '0;
      end else if (en) begin
         if (mode == MODE_LOAD) begin
            shift_cnt <= '0;
         end else if ((mode == MODE_SHL || mode == MODE_SHR) && shift_cnt != CNT_MAX) begin
            shift_cnt <= shift_cnt + CNT_W'(1);
         end
      end
   end

   mode_known_a : assert property (@(posedge Clock) disable iff (rst) en |-> !$isunknown(mode));

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=8, RST_VALUE=8'hA5).
// A driver issues one operation per cycle at the falling edge and pushes the
// model's expected post-edge state; a monitor pops and compares after each
// rising edge. Directed checks cover the reset and boundary scenarios.
module tb_universal_shift_register;

   localparam int             W  = 8;
   localparam int             CW = 4;
   localparam logic [W-1:0]   RV = 8'hA5;
   localparam int             EW = 2 * W + CW + 3;

   logic          Clock = 1'b0;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic [W-1:0]  D;
   logic          sin_l;
   logic          sin_r;
   logic [W-1:0]  Q;
   logic [W-1:0]  Qb;
   logic          sout_l;
   logic          sout_r;
   logic [CW-1:0] shift_cnt;
   logic          done;

   bit clk_on = 1'b0;

   int total = 0;
   int bad   = 0;

   logic [EW-1:0] exp_q[$];
   string         tag_q[$];

   // Reference model state: register value and shift count as plain integers.
   int m_q;
   int m_cnt;

   universal_shift_register #(.WIDTH(W), .RST_VALUE(RV)) dut (
      .Clock     (Clock),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .D         (D),
      .sin_l     (sin_l),
      .sin_r     (sin_r),
      .Q         (Q),
      .Qb        (Qb),
      .sout_l    (sout_l),
      .sout_r    (sout_r),
      .shift_cnt (shift_cnt),
      .done      (done)
   );

   // Clock starts only when enabled so reset can be checked with no edges.
   initial begin
      wait (clk_on);
      forever #5 Clock = ~Clock;
   end

   function automatic logic [EW-1:0] pack(logic [W-1:0] q, logic [W-1:0] qb, logic [CW-1:0] c,
                                          logic d, logic sl, logic sr);
      return {q, qb, c, d, sl, sr};
   endfunction

   function automatic logic [EW-1:0] model_exp();
      logic [W-1:0] qv;
      qv = W'(m_q);
      return pack(qv, W'(255 - m_q), CW'(m_cnt), (m_cnt == W), ((m_q >> (W - 1)) & 1) != 0,
                  (m_q & 1) != 0);
   endfunction

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs now and push the state the model predicts after the next edge.
   task automatic drive_op(input string tag, input logic e, input logic [1:0] m,
                           input logic [W-1:0] d, input logic sl, input logic sr);
      en    = e;
      mode  = m;
      D     = d;
      sin_l = sl;
      sin_r = sr;
      if (e) begin
         if (m == 2'd1 || m == 2'd2) begin
            if (m == 2'd1) m_q = ((m_q * 2) + int'(sl)) % 256;
            else           m_q = (m_q / 2) + (int'(sr) * 128);
            if (m_cnt < W) m_cnt = m_cnt + 1;
         end else if (m == 2'd3) begin
            m_q   = int'(d);
            m_cnt = 0;
         end
      end
      exp_q.push_back(model_exp());
      tag_q.push_back(tag);
   endtask

   task automatic step(input string tag, input logic e, input logic [1:0] m,
                       input logic [W-1:0] d, input logic sl, input logic sr);
      @(negedge Clock);
      drive_op(tag, e, m, d, sl, sr);
   endtask

   task automatic settle();
      @(posedge Clock);
      #2;
   endtask

   // Monitor: after every rising edge, compare against the oldest expectation.
   initial begin
      logic [EW-1:0] e;
      string         t;
      forever begin
         @(posedge Clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, pack(Q, Qb, shift_cnt, done, sout_l, sout_r), e);
         end
      end
   end

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      mode  = 2'b00;
      D     = '0;
      sin_l = 1'b0;
      sin_r = 1'b0;
      m_q   = int'(RV);
      m_cnt = 0;

      // Reset with no clock at all.
      #3;
      check("reset_no_clock", pack(Q, Qb, shift_cnt, done, sout_l, sout_r),
            pack(8'hA5, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b1));

      clk_on = 1'b1;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_held_over_edges", EW'(Q), EW'(8'hA5));
      @(negedge Clock);
      rst = 1'b0;

      // Load then one left shift.
      step("load_3c", 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
      step("shl_1", 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
      settle();
      check("shl_q", EW'(Q), EW'(8'h79));
      check("shl_sout_l", EW'(sout_l), EW'(1'b0));
      check("shl_cnt", EW'(shift_cnt), EW'(4'd1));

      // Eight right shifts to saturation, then one more.
      step("load_81", 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step("shr_run", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
      settle();
      check("shr8_q", EW'(Q), EW'(8'h00));
      check("shr8_done", EW'(done), EW'(1'b1));
      check("shr8_cnt", EW'(shift_cnt), EW'(4'd8));
      step("shr_9th", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
      settle();
      check("shr9_cnt_sat", EW'(shift_cnt), EW'(4'd8));

      // Disabled load must change nothing.
      for (int i = 0; i < 3; i++) step("en0_load", 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0);
      settle();
      check("en0_q", EW'(Q), EW'(8'h00));
      check("en0_cnt", EW'(shift_cnt), EW'(4'd8));

      // Reset pulsed between edges in the middle of a shift sequence.
      step("load_3c_b", 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
      step("shl_a", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
      step("shl_b", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
      @(negedge Clock);
      #1 rst = 1'b1;
      #1;
      check("midop_reset_q", EW'(Q), EW'(8'hA5));
      check("midop_reset_cnt", EW'(shift_cnt), EW'(4'd0));
      #1 rst = 1'b0;
      m_q   = int'(RV);
      m_cnt = 0;
      drive_op("after_reset_shl", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
      settle();
      check("after_reset_q", EW'(Q), EW'(8'h4A));
      check("after_reset_cnt", EW'(shift_cnt), EW'(4'd1));
      step("shl_d", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);

      // Alternating directions share one counter; load clears done.
      step("load_0f", 1'b1, 2'b11, 8'h0F, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step("alt_shl", 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
         step("alt_shr", 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
      end
      settle();
      check("alt_q", EW'(Q), EW'(8'h0F));
      check("alt_cnt", EW'(shift_cnt), EW'(4'd8));
      check("alt_done", EW'(done), EW'(1'b1));
      step("load_clears_done", 1'b1, 2'b11, 8'h55, 1'b0, 1'b0);
      settle();
      check("load_done_low", EW'(done), EW'(1'b0));
      check("load_cnt_zero", EW'(shift_cnt), EW'(4'd0));

      // Randomised operations against the model.
      for (int i = 0; i < 400; i++) begin
         step("random_op", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              W'($urandom), 1'($urandom), 1'($urandom));
      end

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
      #2;
      check("scoreboard_drained", EW'(exp_q.size()), EW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
